lstm_cell_seq: RTL
==================

// Module: lstm_cell_seq
// PURPOSE
//  Time-multiplexed, parametrised LSTM cell: one shared MAC evaluates all
//  4*UNITS gate rows from a weight-memory read port. Holds h/c state
//  internally between steps. Valid/ready handshake on input and output.
//  Sits between the sequence feeder and the dense output layer.
// PARAMETERS
//  DATA_WIDTH  16  word width, two's complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//  FRAC_BITS   8   fractional bits
//  UNITS       4   hidden units (>=1)
//  LUT_DEPTH   16  activation LUT entries, power of 2, 8..2^(FRAC_BITS+3)
// PORTS
//  clk        in   1                      clock, rising edge
//  rst        in   1                      synchronous, active-high reset
//  in_valid   in   1                      xt valid
//  in_ready   out  1                      cell idle, accepts xt
//  xt         in   DATA_WIDTH             input sample
//  clear_st   in   1                      with accept: use h=c=0 for this step
//  w_addr     out  $clog2(4*UNITS*(UNITS+2))  weight-memory address
//  w_data     in   DATA_WIDTH             weight word, valid 1 cycle after w_addr
//  sig_lut    in   LUT_DEPTH*DATA_WIDTH   sigmoid table, entry k at [k*DW+:DW]
//  tanh_lut   in   LUT_DEPTH*DATA_WIDTH   tanh table, same packing
//  out_valid  out  1                      ht/ct hold a new step result
//  out_ready  in   1                      consumer takes result
//  ht         out  UNITS*DATA_WIDTH       h state, unit u at [u*DW+:DW]
//  ct         out  UNITS*DATA_WIDTH       c state, same packing
// BEHAVIOUR
//  Reset: state IDLE, in_ready=0 during rst and 1 the cycle after;
//   out_valid=0, ht=ct=0, w_addr=0. rst mid-step aborts; partial results dropped.
//  Memory map: row r=g*UNITS+u (g: 0=i,1=f,2=g~,3=o); word k of row at
//   r*(UNITS+2)+k; k=0 Wx, k=1..UNITS U[k-1], k=UNITS+1 bias.
//  FSM: IDLE -> ROW -> ACT -> (next row: ROW | last: CELL) -> DONE -> IDLE.
//   IDLE: in_ready=1; accept on in_valid&in_ready, latch xt, clear_st.
//   ROW: issue UNITS+2 addresses on consecutive cycles, 1 drain cycle;
//    acc += w_data*operand (xt, h[k-1] or 0 if clear_st, bias<<FRAC_BITS).
//   ACT: z=sat_DW(acc>>>FRAC_BITS); idx=clamp((z>>>(FRAC_BITS+3-log2 LUT_DEPTH))
//    +LUT_DEPTH/2, 0, LUT_DEPTH-1); gate=sig_lut[idx] (g~: tanh_lut[idx]).
//    LUT spans [-4,+4).
//   CELL: per unit 2 cycles: c'=f*c+i*g~ (c=0 if clear_st); h'=o*tanh_lut[idx(c')].
//    h/c committed only in CELL; all gate rows use the previous h.
//   DONE: out_valid=1; hold ht/ct/out_valid stable until out_ready; then IDLE.
//  Latency: accept edge to out_valid = 4*UNITS*(UNITS+4)+2*UNITS+1 cycles
//   (137 at UNITS=4); in_ready=0 throughout.
//  Arithmetic: products full 2*DW; acc width 2*DW+$clog2(UNITS+2), no wrap;
//   gate/cell products >>>FRAC_BITS, truncate toward -inf, saturate to DW.
//  out_ready while out_valid=0 is ignored; in_valid outside IDLE is ignored.
// TESTING
//  DW=16,FRAC=8,UNITS=4,LUT_DEPTH=16; sig_lut[k]=round(256*sig((k-8)/2)),
//   tanh likewise.
//  1 All weights/bias 0, xt=0x0100 -> idx=8, i=f=o=0x0080, g~=0;
//    ct=ht=0; out_valid exactly 137 cycles after accept.
//  2 Wx(i,g~,o rows)=0x0100, others 0, xt=0x0400 (z=4.0) -> idx=15;
//    ct=sig_lut[15]*tanh_lut[15]>>8 per unit; ht matches model.
//  3 Wx=0x7FFF, xt=0x7FFF -> acc saturates, idx clamps to 15, no wrap;
//    negated xt -> idx 0.
//  4 Two steps, second with clear_st=1 -> same result as first step from reset.
//  5 out_ready low 20 cycles in DONE -> ht/ct/out_valid stable, in_ready=0,
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
//  6 rst asserted at cycle 50 of a step -> next cycle out_valid=0, ht=ct=0;
//    in_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/lstm_cell_seq.sv
// Time-multiplexed LSTM cell: a single MAC walks all 4*UNITS gate rows from an
// external weight memory, applies LUT activations, then updates c/h per unit.
module lstm_cell_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int UNITS      = 4,
  parameter int LUT_DEPTH  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_WIDTH-1:0]                     xt,
  input  logic                                      clear_st,
  output logic [$clog2(4*UNITS*(UNITS+2))-1:0]      w_addr,
  input  logic [DATA_WIDTH-1:0]                     w_data,
  input  logic [LUT_DEPTH*DATA_WIDTH-1:0]           sig_lut,
  input  logic [LUT_DEPTH*DATA_WIDTH-1:0]           tanh_lut,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [UNITS*DATA_WIDTH-1:0]               ht,
  output logic [UNITS*DATA_WIDTH-1:0]               ct
);
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = 2*DW + $clog2(UNITS+2);
  localparam int NR  = 4*UNITS;
  localparam int AWW = $clog2(4*UNITS*(UNITS+2));
  localparam int RW  = $clog2(NR);
  localparam int KW  = $clog2(UNITS+3);
  localparam int UW  = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int LW  = $clog2(LUT_DEPTH);
  localparam int SH  = FRAC_BITS + 3 - LW;

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_ACT, S_CELL, S_DONE} state_t;

  state_t                state_r, state_next_s;
  logic                  in_ready_r, out_valid_r, phase_r, accept_s, is_g_s;
  logic [AWW-1:0]        w_addr_r;
  logic [RW-1:0]         row_r, ii_s, fi_s, gi_s, oi_s;
  logic [KW-1:0]         k_r;
  logic [UW-1:0]         unit_r;
  logic [LW-1:0]         idx_s, cidx_s;
  logic signed [AW-1:0]  acc_r, term_s, csum_s;
  logic signed [DW-1:0]  xt_r, operand_s, z_s, gate_s, th_s, c_next_s, h_next_s;
  logic signed [2*DW-1:0] prod_s, oh_s;
  logic signed [DW-1:0]  h_r    [UNITS];
  logic signed [DW-1:0]  c_r    [UNITS];
  logic signed [DW-1:0]  gate_r [NR];

  // Full-precision signed product; operands pre-extended so no width is lost.
  function automatic logic signed [2*DW-1:0] mul_full(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ae, be;
    ae = {{DW{a[DW-1]}}, a};
    be = {{DW{b[DW-1]}}, b};
    mul_full = ae * be;
  endfunction

  function automatic logic signed [AW-1:0] sext_p(input logic signed [2*DW-1:0] p);
    sext_p = {{(AW-2*DW){p[2*DW-1]}}, p};
  endfunction

  // Clamp a wide value into the DW-bit two's complement range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] hi, lo;
    hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > hi)      sat_dw = hi[DW-1:0];
    else if (v < lo) sat_dw = lo[DW-1:0];
    else             sat_dw = v[DW-1:0];
  endfunction

  // LUT index: table spans [-4,+4), centre entry is zero.
  function automatic logic [LW-1:0] act_idx(input logic signed [DW-1:0] z);
    logic signed [DW+1:0] t;
    t = ($signed({{2{z[DW-1]}}, z}) >>> SH) + (DW+2)'(LUT_DEPTH / 2);
    if (t[DW+1])                          act_idx = '0;
    else if (t > (DW+2)'(LUT_DEPTH - 1))  act_idx = LW'(LUT_DEPTH - 1);
    else                                  act_idx = t[LW-1:0];
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign w_addr    = w_addr_r;
  assign accept_s  = in_valid && in_ready_r;

  // Next-state logic for the row/activation/cell sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: if (accept_s) state_next_s = S_ROW; else state_next_s = S_IDLE;
      S_ROW:  if (k_r == KW'(UNITS+2)) state_next_s = S_ACT; else state_next_s = S_ROW;
      S_ACT:  if (row_r == RW'(NR-1)) state_next_s = S_CELL; else state_next_s = S_ROW;
      S_CELL: if (phase_r && (unit_r == UW'(UNITS-1))) state_next_s = S_DONE;
              else state_next_s = S_CELL;
      S_DONE: if (out_valid_r && out_ready) state_next_s = S_IDLE; else state_next_s = S_DONE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // MAC operand select, activation lookup and cell/hidden update arithmetic.
  always_comb begin
    operand_s = '0;
    for (int u = 0; u < UNITS; u++) begin
      if (k_r == KW'(u+2)) operand_s = h_r[u];
    end
    if (k_r == KW'(1)) operand_s = xt_r;
    prod_s = mul_full($signed(w_data), operand_s);
    if (k_r == KW'(UNITS+2)) term_s = {{(AW-DW-FRAC_BITS){w_data[DW-1]}}, w_data, {FRAC_BITS{1'b0}}};
    else                     term_s = sext_p(prod_s);
    z_s    = sat_dw(acc_r >>> FRAC_BITS);
    idx_s  = act_idx(z_s);
    is_g_s = (row_r >= RW'(2*UNITS)) && (row_r < RW'(3*UNITS));
    if (is_g_s) gate_s = tanh_lut[int'(idx_s)*DW +: DW];
    else        gate_s = sig_lut[int'(idx_s)*DW +: DW];
    ii_s     = RW'(unit_r);
    fi_s     = RW'(UNITS) + ii_s;
    gi_s     = RW'(2*UNITS) + ii_s;
    oi_s     = RW'(3*UNITS) + ii_s;
    csum_s   = sext_p(mul_full(gate_r[fi_s], c_r[unit_r])) + sext_p(mul_full(gate_r[ii_s], gate_r[gi_s]));
    c_next_s = sat_dw(csum_s >>> FRAC_BITS);
    cidx_s   = act_idx(c_r[unit_r]);
    th_s     = tanh_lut[int'(cidx_s)*DW +: DW];
    oh_s     = mul_full(gate_r[oi_s], th_s);
    h_next_s = sat_dw(sext_p(oh_s) >>> FRAC_BITS);
  end

  // Pack the per-unit state onto the output buses.
  always_comb begin
    ht = '0;
    ct = '0;
    for (int u = 0; u < UNITS; u++) begin
      ht[u*DW +: DW] = h_r[u];
      ct[u*DW +: DW] = c_r[u];
    end
  end

  // State register and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == S_IDLE);
      if (state_r == S_DONE && !out_valid_r) out_valid_r <= 1'b1;
      else if (out_valid_r && out_ready)     out_valid_r <= 1'b0;
    end
  end

  // Datapath: address sequencing, accumulation, gate capture, h/c commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_r <= '0;
      row_r    <= '0;
      k_r      <= '0;
      unit_r   <= '0;
      phase_r  <= 1'b0;
      acc_r    <= '0;
      xt_r     <= '0;
      for (int u = 0; u < UNITS; u++) begin
        h_r[u] <= '0;
        c_r[u] <= '0;
      end
      for (int r = 0; r < NR; r++) gate_r[r] <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          w_addr_r <= '0;
          row_r    <= '0;
          k_r      <= '0;
          acc_r    <= '0;
          if (accept_s) begin
            xt_r <= xt;
            if (clear_st) begin
              for (int u = 0; u < UNITS; u++) begin
                h_r[u] <= '0;
                c_r[u] <= '0;
              end
            end
          end
        end
        S_ROW: begin
          k_r <= k_r + KW'(1);
          // Rows are contiguous in memory, so the address simply counts up.
          if (k_r <= KW'(UNITS+1)) w_addr_r <= w_addr_r + AWW'(1);
          if (k_r != '0) acc_r <= acc_r + term_s;
        end
        S_ACT: begin
          gate_r[row_r] <= gate_s;
          row_r   <= row_r + RW'(1);
          k_r     <= '0;
          acc_r   <= '0;
          unit_r  <= '0;
          phase_r <= 1'b0;
        end
        S_CELL: begin
          phase_r <= ~phase_r;
          if (!phase_r) begin
            c_r[unit_r] <= c_next_s;
          end else begin
            h_r[unit_r] <= h_next_s;
            unit_r      <= unit_r + UW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
